// File: rtl/ref_clock_generator_if.sv
// ref_clock_generator_if
//   Groups the run-control, configuration/step handshakes and generated-clock
//   outputs of ref_clock_generator. Clock and reset are plain module ports.
//   master : drives i_* signals, observes o_* signals (testbench / controller)
//   slave  : the generator itself
interface ref_clock_generator_if;
   logic        i_enable;
   logic        i_cfg_valid;
   logic        o_cfg_ready;
   logic [7:0]  i_half_period;
   logic        i_step_valid;
   logic        o_step_ready;
   logic [7:0]  i_step_amt;
   logic        i_step_dir;
   logic        o_ref_clk;
   logic        o_edge;
   logic [15:0] o_period_count;

   modport master (
      output i_enable, i_cfg_valid, i_half_period,
      output i_step_valid, i_step_amt, i_step_dir,
      input  o_cfg_ready, o_step_ready, o_ref_clk, o_edge, o_period_count
   );

   modport slave (
      input  i_enable, i_cfg_valid, i_half_period,
      input  i_step_valid, i_step_amt, i_step_dir,
      output o_cfg_ready, o_step_ready, o_ref_clk, o_edge, o_period_count
   );
endinterface

// File: rtl/ref_clock_generator.sv
// ref_clock_generator
//   Generates a registered square wave o_ref_clk whose half period is
//   (reload + 1) system clocks. reload = hp, optionally lengthened or
//   shortened (saturating at 0) for exactly one half period by a phase step.
//   Ports:
//     i_sys_clk      system clock, rising edge
//     i_rst          synchronous active-high reset
//     bus (slave)    i_enable run request; i_cfg_valid/o_cfg_ready + i_half_period
//                    (half period minus one); i_step_valid/o_step_ready +
//                    i_step_amt/i_step_dir (0 delay, 1 advance); o_ref_clk,
//                    o_edge (pulse on each toggle), o_period_count (rising edges)
//   Optional: define REF_CLOCK_GENERATOR_JITTER_EN to add an 8-bit LFSR
//   (taps 8,6,5,4, seed 0xA5) whose bit 0 is added to every reload; the LFSR
//   advances on every o_ref_clk toggle.
module ref_clock_generator (
   input  logic                 i_sys_clk,
   input  logic                 i_rst,
   ref_clock_generator_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [7:0]  hp_q, hp_d;
   logic        cfg_pend_q, cfg_pend_d;
   logic [7:0]  cfg_val_q, cfg_val_d;
   logic        step_pend_q, step_pend_d;
   logic [7:0]  step_amt_q, step_amt_d;
   logic        step_dir_q, step_dir_d;
   logic        ref_q, ref_d;
   logic        edge_q, edge_d;
   logic [15:0] period_count_q, period_count_d;

   logic        cfg_acc, step_acc;
   logic [7:0]  hp_eff;
   logic        step_vld_eff;
   logic [7:0]  step_amt_eff;
   logic        step_dir_eff;
   logic [8:0]  base, adj, reload;
   logic        do_reload;
   logic        jitter;

   assign cfg_acc  = bus.i_cfg_valid  & ~cfg_pend_q;
   assign step_acc = bus.i_step_valid & ~step_pend_q;

`ifdef REF_CLOCK_GENERATOR_JITTER_EN
   logic [7:0] lfsr_q;
   logic       toggle;

   assign jitter = lfsr_q[0];
   assign toggle = ref_d ^ ref_q;

   always_ff @(posedge i_sys_clk) begin
      if (i_rst)
         lfsr_q <= 8'hA5;
      else if (toggle)
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
`else
   assign jitter = 1'b0;
`endif

   // Values accepted this cycle take precedence over pending ones so a reload
   // coinciding with an accept uses the fresh value.
   always_comb begin
      hp_eff = hp_q;
      if (cfg_pend_q) hp_eff = cfg_val_q;
      if (cfg_acc)    hp_eff = bus.i_half_period;
      step_vld_eff = step_pend_q | step_acc;
      step_amt_eff = step_acc ? bus.i_step_amt : step_amt_q;
      step_dir_eff = step_acc ? bus.i_step_dir : step_dir_q;
      base = {1'b0, hp_eff};
      if (!step_vld_eff)
         adj = base;
      else if (!step_dir_eff)
         adj = base + {1'b0, step_amt_eff};
      else if (step_amt_eff >= hp_eff)
         adj = '0;
      else
         adj = base - {1'b0, step_amt_eff};
      reload = adj + {8'd0, jitter};
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hp_d           = hp_q;
      cfg_pend_d     = cfg_pend_q;
      cfg_val_d      = cfg_val_q;
      step_pend_d    = step_pend_q;
      step_amt_d     = step_amt_q;
      step_dir_d     = step_dir_q;
      ref_d          = ref_q;
      edge_d         = 1'b0;
      do_reload      = 1'b0;

      if (cfg_acc) begin
         cfg_pend_d = 1'b1;
         cfg_val_d  = bus.i_half_period;
      end
      if (step_acc) begin
         step_pend_d = 1'b1;
         step_amt_d  = bus.i_step_amt;
         step_dir_d  = bus.i_step_dir;
      end

      case (state_q)
         ST_IDLE: begin
            // Config lands in hp immediately while idle; steps wait for restart.
            hp_d       = hp_eff;
            cfg_pend_d = 1'b0;
            cnt_d      = '0;
            ref_d      = 1'b0;
            if (bus.i_enable) begin
               state_d   = ST_HIGH;
               ref_d     = 1'b1;
               edge_d    = 1'b1;
               do_reload = 1'b1;
            end
         end
         ST_HIGH: begin
            // A high phase always runs to completion, even when disabled.
            if (cnt_q == 9'd0) begin
               ref_d  = 1'b0;
               edge_d = 1'b1;
               if (bus.i_enable) begin
                  state_d   = ST_LOW;
                  do_reload = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         ST_LOW: begin
            if (!bus.i_enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 9'd0) begin
               state_d   = ST_HIGH;
               ref_d     = 1'b1;
               edge_d    = 1'b1;
               do_reload = 1'b1;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ref_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase

      if (do_reload) begin
         cnt_d       = reload;
         hp_d        = hp_eff;
         cfg_pend_d  = 1'b0;
         step_pend_d = 1'b0;
      end

      period_count_d = period_count_q + {15'd0, ref_d & ~ref_q};
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         hp_q           <= '0;
         cfg_pend_q     <= 1'b0;
         cfg_val_q      <= '0;
         step_pend_q    <= 1'b0;
         step_amt_q     <= '0;
         step_dir_q     <= 1'b0;
         ref_q          <= 1'b0;
         edge_q         <= 1'b0;
         period_count_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         hp_q           <= hp_d;
         cfg_pend_q     <= cfg_pend_d;
         cfg_val_q      <= cfg_val_d;
         step_pend_q    <= step_pend_d;
         step_amt_q     <= step_amt_d;
         step_dir_q     <= step_dir_d;
         ref_q          <= ref_d;
         edge_q         <= edge_d;
         period_count_q <= period_count_d;
      end
   end

   assign bus.o_ref_clk      = ref_q;
   assign bus.o_edge         = edge_q;
   assign bus.o_period_count = period_count_q;
   assign bus.o_cfg_ready    = ~cfg_pend_q;
   assign bus.o_step_ready   = ~step_pend_q;

endmodule

// File: doc/ref_clock_generator.md
REF_CLOCK_GENERATOR -- requirements
Module: ref_clock_generator

Interface
REQ-001 SHALL: i_sys_clk  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL: i_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: i_enable  in  1  run request.
REQ-004 SHALL: i_cfg_valid  in  1 / o_cfg_ready  out  1  half-period config handshake.
REQ-005 SHALL: i_half_period  in  8  half period minus one, in sys clocks.
REQ-006 SHALL: i_step_valid  in  1 / o_step_ready  out  1  phase-step handshake.
REQ-007 SHALL: i_step_amt  in  8  phase-step size, in sys clocks.
REQ-008 SHALL: i_step_dir  in  1  0 = delay (lengthen), 1 = advance (shorten).
REQ-009 SHALL: o_ref_clk  out  1  generated square wave, registered.
REQ-010 SHALL: o_edge  out  1  one-cycle pulse in the cycle o_ref_clk changes.
REQ-011 SHALL: o_period_count  out  16  count of o_ref_clk rising edges.

Function
REQ-012 SHALL: FSM states IDLE, HIGH, LOW; 9-bit down-counter cnt; active half period hp (8 bit).
REQ-013 SHALL: IDLE with i_enable=1 -> HIGH next cycle: o_ref_clk=1, o_edge=1, cnt loaded with reload value.
REQ-014 SHALL: in HIGH/LOW, cnt decrements each cycle; at cnt==0 toggle o_ref_clk, pulse o_edge, reload cnt; each half period = reload+1 cycles.
REQ-015 SHALL: base reload = hp; delay step adds i_step_amt (9-bit, no overflow); advance step subtracts, saturating at 0.
REQ-016 SHALL: a pending step affects exactly one reload, then clears.
REQ-017 SHALL: config accepted on i_cfg_valid & o_cfg_ready; held pending; copied to hp at next reload, or immediately in IDLE.
REQ-018 SHALL: o_cfg_ready = 1 when no config pending; o_step_ready = 1 when no step pending.
REQ-019 SHALL: accept and reload in the same cycle -> that reload uses the newly accepted value (config and step alike).
REQ-020 SHALL: second valid while ready=0 ignored; no overwrite of pending value.
REQ-021 SHALL: i_enable=0 in LOW -> IDLE next cycle, no edge; in HIGH -> finish half period, falling edge, then IDLE; o_ref_clk is never shortened below the loaded half period.
REQ-022 SHALL: in IDLE, a pending step stays pending and applies to the first reload after restart.
REQ-023 SHALL: o_period_count increments in each cycle a rising edge is produced; wraps 0xFFFF -> 0x0000.

Reset
REQ-024 SHALL: on i_rst: state IDLE, o_ref_clk=0, o_edge=0, cnt=0, hp=0, o_period_count=0, pendings cleared, o_cfg_ready=1, o_step_ready=1.
REQ-025 SHALL: reset mid-period takes effect next edge regardless of state; any pending config/step discarded.

Configuration
REQ-026 SHALL: macro REF_CLOCK_GENERATOR_JITTER_EN defined -> 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 0xA5 on reset, advances on every o_ref_clk toggle; LFSR bit0 (pre-advance) added to every reload.
REQ-027 SHALL: macro undefined -> no LFSR, no jitter; reload per REQ-015 only; ports unchanged.

Verification (macro undefined unless stated)
REQ-028 SHALL: hp=3, enable=1 -> o_ref_clk 4 cycles high, 4 low, period 8; o_period_count +1 per 8 cycles.
REQ-029 SHALL: hp=3, step delay amt=2 accepted mid-HIGH -> next half period 6 cycles, following 4; o_step_ready low until applied.
REQ-030 SHALL: hp=3, step advance amt=10 -> one half period of 1 cycle, then 4.
REQ-031 SHALL: config hp=7 accepted mid-half-period while hp=3 -> current half period completes at 4, next 8; second valid before apply ignored.
REQ-032 SHALL: enable dropped 1 cycle into HIGH (hp=3) -> 3 more high cycles, falling edge, IDLE, o_ref_clk=0; o_period_count preset to 0xFFFF wraps to 0x0000 on next rising edge.
REQ-033 SHALL: with REF_CLOCK_GENERATOR_JITTER_EN, hp=3 -> every half period 4 or 5 cycles, sequence matching LFSR seeded 0xA5.
